// File: rtl/up_pkg.sv
// rtl/up_pkg.sv - shared ALU opcodes and control-word bit positions
package up_pkg;

    localparam logic [2:0] ALU_PASS_A = 3'b000;
    localparam logic [2:0] ALU_SUB    = 3'b001;
    localparam logic [2:0] ALU_PASS_B = 3'b010;
    localparam logic [2:0] ALU_ADD    = 3'b011;
    localparam logic [2:0] ALU_NAND   = 3'b100;
    localparam logic [2:0] ALU_AND    = 3'b101;
    localparam logic [2:0] ALU_OR     = 3'b110;
    localparam logic [2:0] ALU_XOR    = 3'b111;

    // 13-bit control word produced by the decoder, MSB first
    localparam int CW_W          = 13;
    localparam int CW_INC_PC     = 12;
    localparam int CW_LOAD_PC    = 11;
    localparam int CW_LOAD_A     = 10;
    localparam int CW_LOAD_FLAGS = 9;
    localparam int CW_OP_ALU_HI  = 8;
    localparam int CW_OP_ALU_LO  = 6;
    localparam int CW_CS         = 5;
    localparam int CW_WE         = 4;
    localparam int CW_EO_ALU     = 3;
    localparam int CW_OE_IN      = 2;
    localparam int CW_OE_OPRND   = 1;
    localparam int CW_LOAD_OUT   = 0;

endpackage

// File: rtl/up_execute_alu4.sv
// rtl/up_execute_alu4.sv - 4-bit combinational ALU with carry/borrow and zero outputs
module alu4
    import up_pkg::*;
(
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic [2:0] op,
    output logic [3:0] y,
    output logic       c,
    output logic       z
);

    logic [4:0] sum;
    logic [4:0] diff;

    // Bit 4 of the widened difference is the borrow, set exactly when a < b
    assign sum  = {1'b0, a} + {1'b0, b};
    assign diff = {1'b0, a} - {1'b0, b};

    always_comb begin
        y = 4'h0;
        c = 1'b0;
        case (op)
            ALU_PASS_A: y = a;
            ALU_SUB:    {c, y} = diff;
            ALU_PASS_B: y = b;
            ALU_ADD:    {c, y} = sum;
            ALU_NAND:   y = ~(a & b);
            ALU_AND:    y = a & b;
            ALU_OR:     y = a | b;
            ALU_XOR:    y = a ^ b;
            default:    y = 4'h0;
        endcase
    end

    assign z = (y == 4'h0);

endmodule

// File: rtl/up_execute.sv
// rtl/up_execute.sv - execute stage: accumulator, ALU, flags, data RAM, bus mux, output latch
module up_execute
    import up_pkg::*;
#(
    parameter int RAM_AW = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ena,
    input  logic        loadA,
    input  logic        loadFlags,
    input  logic [2:0]  opALU,
    input  logic        cs,
    input  logic        we,
    input  logic        eoALU,
    input  logic        oeIn,
    input  logic        oeOprnd,
    input  logic        loadOut,
    input  logic [3:0]  oprnd,
    input  logic [3:0]  pushbuttons,
    input  logic [11:0] address_RAM,
    output logic [3:0]  data_bus,
    output logic [3:0]  accu,
    output logic [3:0]  FF_out,
    output logic        c_flag,
    output logic        z_flag
);

    localparam int RAM_DEPTH = 1 << RAM_AW;

    logic [3:0]        ram_q [RAM_DEPTH];
    logic [RAM_AW-1:0] addr;
    logic [3:0]        src;
    logic [3:0]        alu_y;
    logic              alu_c;
    logic              alu_z;

    logic [3:0] accu_q,   accu_d;
    logic [3:0] ff_out_q, ff_out_d;
    logic       c_q,      c_d;
    logic       z_q,      z_d;

    assign addr = address_RAM[RAM_AW-1:0];

    generate
        if (RAM_AW < 12) begin : g_addr_unused
            logic unused_addr_hi;
            assign unused_addr_hi = ^address_RAM[11:RAM_AW];
        end
    endgenerate

    always_comb begin
        src = 4'h0;
        if (oeOprnd)
            src = oprnd;
        else if (oeIn)
            src = pushbuttons;
        else if (cs && !we)
            src = ram_q[addr];
    end

    alu4 u_alu (
        .a  (accu_q),
        .b  (src),
        .op (opALU),
        .y  (alu_y),
        .c  (alu_c),
        .z  (alu_z)
    );

    // ALU B is taken from src, never from data_bus, so the bus mux cannot loop
    assign data_bus = eoALU ? alu_y : src;

    always_comb begin
        accu_d   = accu_q;
        ff_out_d = ff_out_q;
        c_d      = c_q;
        z_d      = z_q;
        if (ena) begin
            if (loadA)     accu_d   = alu_y;
            if (loadFlags) {c_d, z_d} = {alu_c, alu_z};
            if (loadOut)   ff_out_d = data_bus;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            accu_q   <= 4'h0;
            ff_out_q <= 4'h0;
            c_q      <= 1'b0;
            z_q      <= 1'b0;
        end else begin
            accu_q   <= accu_d;
            ff_out_q <= ff_out_d;
            c_q      <= c_d;
            z_q      <= z_d;
        end
    end

    // RAM is not cleared, but a write is dropped while reset is held
    always_ff @(posedge clk) begin
        if (rst_n && ena && cs && we)
            ram_q[addr] <= data_bus;
    end

    assign accu   = accu_q;
    assign FF_out = ff_out_q;
    assign c_flag = c_q;
    assign z_flag = z_q;

endmodule

// File: tb/tb_up_execute.sv
// tb/tb_up_execute.sv - directed self-checking bench for up_execute
module tb_up_execute;
    import up_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ena;
    logic        loadA;
    logic        loadFlags;
    logic [2:0]  opALU;
    logic        cs;
    logic        we;
    logic        eoALU;
    logic        oeIn;
    logic        oeOprnd;
    logic        loadOut;
    logic [3:0]  oprnd;
    logic [3:0]  pushbuttons;
    logic [11:0] address_RAM;
    logic [3:0]  data_bus;
    logic [3:0]  accu;
    logic [3:0]  FF_out;
    logic        c_flag;
    logic        z_flag;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    up_execute #(.RAM_AW(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ena         (ena),
        .loadA       (loadA),
        .loadFlags   (loadFlags),
        .opALU       (opALU),
        .cs          (cs),
        .we          (we),
        .eoALU       (eoALU),
        .oeIn        (oeIn),
        .oeOprnd     (oeOprnd),
        .loadOut     (loadOut),
        .oprnd       (oprnd),
        .pushbuttons (pushbuttons),
        .address_RAM (address_RAM),
        .data_bus    (data_bus),
        .accu        (accu),
        .FF_out      (FF_out),
        .c_flag      (c_flag),
        .z_flag      (z_flag)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        ena = 1'b1; loadA = 1'b0; loadFlags = 1'b0; opALU = ALU_PASS_A;
        cs = 1'b0; we = 1'b0; eoALU = 1'b0; oeIn = 1'b0; oeOprnd = 1'b0;
        loadOut = 1'b0; oprnd = 4'h0; pushbuttons = 4'h0; address_RAM = 12'h000;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic load_accu(input logic [3:0] v);
        idle();
        oeOprnd = 1'b1; oprnd = v; opALU = ALU_PASS_B; loadA = 1'b1;
        step();
        idle();
    endtask

    initial begin
        idle();
        rst_n = 1'b0;
        loadA = 1'b1; loadOut = 1'b1; oeOprnd = 1'b1; oprnd = 4'h7;
        opALU = ALU_PASS_B; eoALU = 1'b1;
        step(); step();
        chk("rst_accu", {4'h0, accu}, 8'h00);
        chk("rst_ffout", {4'h0, FF_out}, 8'h00);
        chk("rst_c", {7'h0, c_flag}, 8'h00);
        chk("rst_z", {7'h0, z_flag}, 8'h00);

        rst_n = 1'b1;
        idle();
        oeOprnd = 1'b1; oprnd = 4'h5; opALU = ALU_PASS_B; loadA = 1'b1;
        step();
        chk("first_load", {4'h0, accu}, 8'h05);

        load_accu(4'h9);
        oeOprnd = 1'b1; oprnd = 4'h8; opALU = ALU_ADD; loadA = 1'b1; loadFlags = 1'b1;
        step();
        chk("add9_8_accu", {4'h0, accu}, 8'h01);
        chk("add9_8_c", {7'h0, c_flag}, 8'h01);
        chk("add9_8_z", {7'h0, z_flag}, 8'h00);

        load_accu(4'h8);
        oeOprnd = 1'b1; oprnd = 4'h8; opALU = ALU_ADD; loadA = 1'b1; loadFlags = 1'b1;
        step();
        chk("add8_8_accu", {4'h0, accu}, 8'h00);
        chk("add8_8_c", {7'h0, c_flag}, 8'h01);
        chk("add8_8_z", {7'h0, z_flag}, 8'h01);

        load_accu(4'h3);
        oeOprnd = 1'b1; oprnd = 4'h4; opALU = ALU_SUB; loadFlags = 1'b1; eoALU = 1'b1;
        #1 chk("sub3_4_bus", {4'h0, data_bus}, 8'h0f);
        step();
        chk("sub3_4_c", {7'h0, c_flag}, 8'h01);
        chk("sub3_4_z", {7'h0, z_flag}, 8'h00);
        chk("sub3_4_accu", {4'h0, accu}, 8'h03);
        oprnd = 4'h3;
        step();
        chk("sub3_3_c", {7'h0, c_flag}, 8'h00);
        chk("sub3_3_z", {7'h0, z_flag}, 8'h01);

        load_accu(4'hA);
        opALU = ALU_PASS_A; eoALU = 1'b1; cs = 1'b1; we = 1'b1; address_RAM = 12'h003;
        #1 chk("ram_wr_bus", {4'h0, data_bus}, 8'h0a);
        step();
        load_accu(4'h0);
        cs = 1'b1; we = 1'b0; address_RAM = 12'h003; opALU = ALU_PASS_B; loadA = 1'b1;
        step();
        chk("ram_rd_accu", {4'h0, accu}, 8'h0a);
        idle();
        cs = 1'b1; address_RAM = 12'h013;
        #1 chk("ram_alias_rd", {4'h0, data_bus}, 8'h0a);

        load_accu(4'h5);
        opALU = ALU_PASS_A; eoALU = 1'b1; cs = 1'b1; we = 1'b1; address_RAM = 12'h013;
        step();
        idle();
        cs = 1'b1; address_RAM = 12'h003;
        #1 chk("ram_alias_wr", {4'h0, data_bus}, 8'h05);

        idle();
        pushbuttons = 4'h6; oeIn = 1'b1; loadOut = 1'b1;
        step();
        chk("io_ffout", {4'h0, FF_out}, 8'h06);
        idle();
        pushbuttons = 4'h6; oeIn = 1'b1; oeOprnd = 1'b1; oprnd = 4'h2;
        #1 chk("prio_bus", {4'h0, data_bus}, 8'h02);

        idle();
        oeOprnd = 1'b1; oprnd = 4'h1; opALU = ALU_ADD; eoALU = 1'b1;
        loadA = 1'b1; loadOut = 1'b1;
        step();
        chk("coinc_accu", {4'h0, accu}, 8'h06);
        chk("coinc_ffout", {4'h0, FF_out}, 8'h06);
        chk("coinc_bus", {4'h0, data_bus}, 8'h07);

        idle();
        ena = 1'b0; loadA = 1'b1; loadFlags = 1'b1; loadOut = 1'b1;
        cs = 1'b1; we = 1'b1; address_RAM = 12'h003; eoALU = 1'b1;
        oeOprnd = 1'b1; oprnd = 4'hC; opALU = ALU_ADD;
        #1 chk("hold_bus", {4'h0, data_bus}, 8'h02);
        step();
        chk("hold_accu", {4'h0, accu}, 8'h06);
        chk("hold_ffout", {4'h0, FF_out}, 8'h06);
        chk("hold_flags", {6'h0, c_flag, z_flag}, 8'h01);
        oprnd = 4'h1;
        #1 chk("hold_bus_track", {4'h0, data_bus}, 8'h07);
        idle();
        cs = 1'b1; address_RAM = 12'h003;
        #1 chk("hold_ram", {4'h0, data_bus}, 8'h05);

        idle();
        loadA = 1'b1; loadOut = 1'b1; loadFlags = 1'b1; cs = 1'b1; we = 1'b1;
        address_RAM = 12'h003; oeOprnd = 1'b1; oprnd = 4'h9; opALU = ALU_PASS_B; eoALU = 1'b1;
        #2 rst_n = 1'b0;
        #1 chk("midrst_accu", {4'h0, accu}, 8'h00);
        chk("midrst_ffout", {4'h0, FF_out}, 8'h00);
        chk("midrst_flags", {6'h0, c_flag, z_flag}, 8'h00);
        step();
        rst_n = 1'b1;
        idle();
        cs = 1'b1; address_RAM = 12'h003;
        #1 chk("midrst_ram", {4'h0, data_bus}, 8'h05);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/up_execute.md
# up_execute

Execute stage of the 4-bit microprocessor. It sits directly downstream of the decode/fetch logic and consumes the 13-bit control word fields, the fetched operand nibble and the RAM address. It holds the accumulator, the ALU, the C/Z flag register, a small data RAM, the data-bus source mux and the output latch. Its registered `c_flag`/`z_flag` feed back into the decoder input.

## Interface
- `RAM_AW`, default 4: data-RAM address width. The low `RAM_AW` bits of `address_RAM` are used, giving 2^RAM_AW nibbles.
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `ena`  in  1: global enable. Every register and RAM write is qualified by `ena=1`.
- `loadA`  in  1: capture ALU result into the accumulator.
- `loadFlags`  in  1: capture ALU carry/zero into the flags.
- `opALU`  in  3: ALU operation.
- `cs`  in  1: RAM chip select.
- `we`  in  1: RAM write (1) / read (0).
- `eoALU`  in  1: ALU result drives `data_bus`.
- `oeIn`  in  1: `pushbuttons` drives the operand source.
- `oeOprnd`  in  1: `oprnd` drives the operand source.
- `loadOut`  in  1: capture `data_bus` into `FF_out`.
- `oprnd`  in  4: immediate operand from the fetch stage.
- `pushbuttons`  in  4: external input port.
- `address_RAM`  in  12: data-RAM address.
- `data_bus`  out  4: internal bus, combinational.
- `accu`  out  4: accumulator, registered.
- `FF_out`  out  4: output port latch, registered.
- `c_flag`, `z_flag`  out  1 each: flags, registered.

## Operation
- **Operand source `src`**, with a fixed priority:
  - `oeOprnd` → `oprnd`
  - else `oeIn` → `pushbuttons`
  - else `cs & ~we` → `RAM[addr]`
  - else 4'h0
- **Data bus**: `data_bus = eoALU ? alu_y : src`. The ALU B input is always `src` and never `data_bus`, so there is no combinational loop.
- **ALU**: A = `accu`, B = `src`. All results are 4 bits.

| `opALU` | Name | Result | C |
|---|---|---|---|
| 000 | PASS_A | A | 0 |
| 001 | SUB | A−B | borrow, 1 when A<B |
| 010 | PASS_B | B | 0 |
| 011 | ADD | A+B | carry out of bit 3 |
| 100 | NAND | ~(A&B) | 0 |
| 101 | AND | A&B | 0 |
| 110 | OR | A\|B | 0 |
| 111 | XOR | A^B | 0 |

- **Zero flag**: `z = (alu_y == 0)` for every op.
- **On a rising `clk` with `ena=1`**:
  - `loadA`: `accu <= alu_y`.
  - `loadFlags`: `{c_flag,z_flag} <= {c,z}`.
  - `loadOut`: `FF_out <= data_bus`.
  - `cs & we`: `RAM[addr] <= data_bus`.
- **Independent actions**: the actions above are independent and may coincide in one edge. Each register samples pre-edge values, so `loadA` with `loadOut` latches the bus value that existed before `accu` changed.
- **`ena=0`**: all state holds and the combinational outputs still follow their inputs.
- **Reset**: `accu`, `FF_out`, `c_flag` and `z_flag` go to 0 immediately on `rst_n=0`. RAM contents are not reset and are undefined until written. A reset asserted mid-operation aborts any pending write.

## Timing
- `data_bus` and the ALU are zero-latency combinational paths.
- Register and RAM updates become visible 1 cycle after the control is asserted, i.e. after the edge.
- RAM reads are asynchronous. A read of an address written at edge N returns the new value after edge N.
- Flags change only on `loadFlags` edges. The decoder sees the new flags from the cycle following the load.
- Release of `rst_n` is asynchronous to `clk`. The first capture happens on the first rising edge with `rst_n=1` and `ena=1`.

## Structure
- **Package `up_pkg`**: ALU opcode localparams `ALU_PASS_A` … `ALU_XOR` and the control-word bit positions (12 `incPC` … 0 `loadOut`). This package is shared with the decoder.
- **Sub-module `alu4`**: combinational; inputs A, B, op; outputs y, c, z.
- **Top**: the RAM array, the muxes and the registers live in `up_execute` itself.

## Test plan
- **Reset**: hold `rst_n=0` with `loadA`/`loadOut` pulsing → `accu`=0, `FF_out`=0, `c_flag`=0, `z_flag`=0. Release, then `oeOprnd=1`, `oprnd`=5, `opALU`=PASS_B, `loadA` → `accu`=5 after 1 edge.
- **ADD carry**: `accu`=9, `oprnd`=8, ADD, `loadA`+`loadFlags` → `accu`=1, C=1, Z=0. Then `accu`=8, `oprnd`=8, ADD → `accu`=0, C=1, Z=1.
- **SUB/compare**: `accu`=3, `oprnd`=4, SUB, `loadFlags` only → C=1, Z=0, `accu` stays 3. With `oprnd`=3 → C=0, Z=1.
- **RAM round trip**: `accu`=0xA, PASS_A, `eoALU`, `cs`=1, `we`=1, addr=0x003 → RAM[3]=0xA. Then `cs`=1, `we`=0, addr=0x003, PASS_B, `loadA` with `accu` pre-cleared to 0 → `accu`=0xA. Also check that addr 0x013 aliases to entry 3 when `RAM_AW`=4.
- **Input/output and priority**: `pushbuttons`=0x6, `oeIn`, `loadOut` → `FF_out`=6. Assert `oeOprnd` (`oprnd`=2) together with `oeIn` → `data_bus`=2.
- **Enable/hold**: `ena=0` with every load and write asserted → no register or RAM entry changes while `data_bus` still tracks `src`. Assert `rst_n=0` mid-sequence → outputs clear within the same cycle.
